// File: rtl/ipc_mailbox_pkg.sv
// ipc_mailbox_pkg
//   Shared types and constants for the IPC mailbox fabric-side message sender.
//   Holds the sender FSM state enum, the APB address/data widths, the message
//   word count width, the default register map and an address helper.
package ipc_mailbox_pkg;

    localparam int unsigned APB_ADDR_W = 6;
    localparam int unsigned APB_DATA_W = 32;
    // Word count / index width; wide enough for a 16-word message.
    localparam int unsigned CNT_W      = 5;

    localparam logic [APB_ADDR_W-1:0] DEF_MSG_BASE_ADDR = 6'h00;
    localparam logic [APB_ADDR_W-1:0] DEF_DOORBELL_ADDR = 6'h3C;

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_DB_SETUP  = 3'd3,
        ST_DB_ACCESS = 3'd4,
        ST_WAIT_ACK  = 3'd5
    } msg_state_e;

    // Byte address of message word idx; wraps within the 6-bit APB space.
    function automatic logic [APB_ADDR_W-1:0] word_addr(
        input logic [APB_ADDR_W-1:0] base,
        input logic [CNT_W-1:0]      idx
    );
        return APB_ADDR_W'(base + (APB_ADDR_W'(idx) << 2));
    endfunction

endpackage

// File: rtl/ipc_mailbox_msg_sender_buffer.sv
// ipc_msg_buffer
//   MESSAGE_DEPTH x 32-bit message store. Words are written at index = count,
//   count advances per write, and the words are read back by index while the
//   message is pushed over APB.
// Ports:
//   pclk, preset     clock, synchronous active-high reset (clears store+count)
//   clr              drop the current message (count back to 0)
//   wr_en/wr_data    write one word at the current count (ignored when full)
//   wr_last          incoming word carries the end-of-message marker
//   rd_idx/rd_data   indexed combinational read
//   count            number of words held
//   space            count < MESSAGE_DEPTH
//   wr_is_last       incoming word closes the message (marker or last slot)
//   wr_overlong      incoming word fills the last slot without the marker
module ipc_msg_buffer
    import ipc_mailbox_pkg::*;
#(
    parameter int unsigned MESSAGE_DEPTH = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [APB_DATA_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic [CNT_W-1:0]      rd_idx,
    output logic [APB_DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]      count,
    output logic                  space,
    output logic                  wr_is_last,
    output logic                  wr_overlong
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MESSAGE_DEPTH);

    logic [APB_DATA_W-1:0] mem [MESSAGE_DEPTH];
    logic                  at_last_slot;

    assign space        = count < DEPTH_C;
    assign at_last_slot = count == (DEPTH_C - CNT_W'(1));
    assign wr_is_last   = wr_last || at_last_slot;
    assign wr_overlong  = at_last_slot && !wr_last;

    always_ff @(posedge pclk) begin
        if (preset) begin
            count <= '0;
            for (int i = 0; i < int'(MESSAGE_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
        end else if (wr_en && space) begin
            // Decoded write keeps the index width independent of the depth.
            for (int i = 0; i < int'(MESSAGE_DEPTH); i++) begin
                if (count == CNT_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
            count <= count + CNT_W'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(MESSAGE_DEPTH); i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/ipc_mailbox_msg_sender.sv
// ipc_mailbox_msg_sender
//   Fabric-side producer for one IPC mailbox port. Collects a message from a
//   valid/ready word stream, writes it into the mailbox message registers over
//   APB, rings the doorbell, then waits for the peer's acknowledge interrupt.
// Ports:
//   pclk, preset            clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   message word stream in
//   m_psel..m_pslverr       APB master towards the mailbox (write only)
//   msg_ack_irq             level acknowledge from the peer
//   busy                    message being sent or awaiting ack
//   err                     sticky: overlong message, APB slave error, ack timeout
//   sent_count              acknowledged messages (wraps)
// Build option:
//   IPC_MSG_SENDER_TIMEOUT_EN  bound the ack wait to TIMEOUT_CYCLES cycles.
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_FILL      | accepting stream words into the buffer
// ST_SETUP     | APB setup phase for message word idx
// ST_ACCESS    | APB access phase for word idx, held until m_pready
// ST_DB_SETUP  | APB setup phase for the doorbell write
// ST_DB_ACCESS | APB access phase for the doorbell, held until m_pready
// ST_WAIT_ACK  | bus idle, waiting for msg_ack_irq
module ipc_mailbox_msg_sender
    import ipc_mailbox_pkg::*;
#(
    parameter int unsigned                  MESSAGE_DEPTH  = 1,
    parameter logic [APB_ADDR_W-1:0]        MSG_BASE_ADDR  = DEF_MSG_BASE_ADDR,
    parameter logic [APB_ADDR_W-1:0]        DOORBELL_ADDR  = DEF_DOORBELL_ADDR,
    parameter logic [APB_DATA_W-1:0]        DOORBELL_VALUE = 32'h1,
    parameter int unsigned                  TIMEOUT_CYCLES = 65535
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [APB_DATA_W-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic [APB_ADDR_W-1:0] m_paddr,
    output logic                  m_pwrite,
    output logic [APB_DATA_W-1:0] m_pwdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,
    input  logic                  msg_ack_irq,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           sent_count
);

    msg_state_e            state, state_nxt;
    logic [CNT_W-1:0]      idx;
    logic [CNT_W-1:0]      count;
    logic [APB_DATA_W-1:0] rd_data;
    logic                  space, wr_is_last, wr_overlong;
    logic                  accept, xfer_done, last_word, ack_take, timeout, buf_clr;

    assign accept    = s_valid && s_ready;
    assign xfer_done = ((state == ST_ACCESS) || (state == ST_DB_ACCESS)) && m_pready;
    assign last_word = idx == (count - CNT_W'(1));
    assign ack_take  = (state == ST_WAIT_ACK) && msg_ack_irq;
    assign buf_clr   = ack_take || timeout;

    ipc_msg_buffer #(
        .MESSAGE_DEPTH(MESSAGE_DEPTH)
    ) u_buf (
        .pclk       (pclk),
        .preset     (preset),
        .clr        (buf_clr),
        .wr_en      (accept),
        .wr_data    (s_data),
        .wr_last    (s_last),
        .rd_idx     (idx),
        .rd_data    (rd_data),
        .count      (count),
        .space      (space),
        .wr_is_last (wr_is_last),
        .wr_overlong(wr_overlong)
    );

`ifdef IPC_MSG_SENDER_TIMEOUT_EN
    // Down-counter reloaded outside WAIT_ACK; terminal count on the
    // TIMEOUT_CYCLES-th WAIT_ACK cycle. An ack in that cycle still wins.
    localparam logic [31:0] TMR_LOAD = 32'(TIMEOUT_CYCLES) - 32'd1;
    logic [31:0] ack_tmr;

    always_ff @(posedge pclk) begin
        if (preset || (state != ST_WAIT_ACK)) begin
            ack_tmr <= TMR_LOAD;
        end else if (ack_tmr != 32'd0) begin
            ack_tmr <= ack_tmr - 32'd1;
        end
    end

    assign timeout = (state == ST_WAIT_ACK) && (ack_tmr == 32'd0) && !msg_ack_irq;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FILL:      if (accept && wr_is_last) state_nxt = ST_SETUP;
            ST_SETUP:     state_nxt = ST_ACCESS;
            ST_ACCESS:    if (m_pready) state_nxt = last_word ? ST_DB_SETUP : ST_SETUP;
            ST_DB_SETUP:  state_nxt = ST_DB_ACCESS;
            ST_DB_ACCESS: if (m_pready) state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (buf_clr) state_nxt = ST_FILL;
            default:      state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            idx        <= '0;
            err        <= 1'b0;
            sent_count <= '0;
        end else begin
            if (state == ST_FILL) begin
                idx <= '0;
            end else if ((state == ST_ACCESS) && m_pready) begin
                idx <= idx + CNT_W'(1);
            end
            if ((accept && wr_overlong) || (xfer_done && m_pslverr) || timeout) begin
                err <= 1'b1;
            end
            if (ack_take) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    // Address/data come straight from state and idx, so they are stable from
    // setup through the completing access cycle.
    always_comb begin
        s_ready   = 1'b0;
        m_psel    = 1'b0;
        m_penable = 1'b0;
        m_paddr   = '0;
        m_pwdata  = '0;
        busy      = state != ST_FILL;
        unique case (state)
            ST_FILL: begin
                s_ready = space;
            end
            ST_SETUP, ST_ACCESS: begin
                m_psel    = 1'b1;
                m_penable = state == ST_ACCESS;
                m_paddr   = word_addr(MSG_BASE_ADDR, idx);
                m_pwdata  = rd_data;
            end
            ST_DB_SETUP, ST_DB_ACCESS: begin
                m_psel    = 1'b1;
                m_penable = state == ST_DB_ACCESS;
                m_paddr   = DOORBELL_ADDR;
                m_pwdata  = DOORBELL_VALUE;
            end
            default: begin
            end
        endcase
        m_pwrite = m_psel;
    end

endmodule

// File: tb/tb_ipc_mailbox_msg_sender.sv
// tb_ipc_mailbox_msg_sender
//   Directed bench: a 4-deep sender (ack timeout of 10 when the option is
//   built in) carries most sequences; a 2-deep sender covers overlong messages.
module tb_ipc_mailbox_msg_sender;

    logic        pclk = 1'b0;
    logic        preset;

    logic        s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [5:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic        msg_ack_irq, busy, err;
    logic [15:0] sent_count;

    logic        b_valid, b_last, b_ready;
    logic [31:0] b_data;
    logic        b_psel, b_penable, b_pwrite;
    logic [5:0]  b_paddr;
    logic [31:0] b_pwdata;
    logic        b_ack, b_busy, b_err;
    logic [15:0] b_sent;

    int vecs = 0;
    int errs = 0;

    always #5 pclk = ~pclk;

    ipc_mailbox_msg_sender #(
        .MESSAGE_DEPTH (4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .pclk(pclk), .preset(preset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
        .m_pwdata(m_pwdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .msg_ack_irq(msg_ack_irq), .busy(busy), .err(err), .sent_count(sent_count)
    );

    ipc_mailbox_msg_sender #(
        .MESSAGE_DEPTH(2)
    ) dut2 (
        .pclk(pclk), .preset(preset),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_last(b_last),
        .m_psel(b_psel), .m_penable(b_penable), .m_paddr(b_paddr), .m_pwrite(b_pwrite),
        .m_pwdata(b_pwdata), .m_pready(1'b1), .m_pslverr(1'b0),
        .msg_ack_irq(b_ack), .busy(b_busy), .err(b_err), .sent_count(b_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        chk("push.s_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One APB write: checks setup, then the access phase held for waits cycles
    // with m_pready low before completing.
    task automatic xfer(input string tag, input logic [5:0] a, input logic [31:0] d,
                        input int waits, input logic slverr);
        chk({tag, ".su.psel"}, m_psel, 1);
        chk({tag, ".su.penable"}, m_penable, 0);
        chk({tag, ".su.addr"}, m_paddr, a);
        chk({tag, ".su.data"}, m_pwdata, d);
        chk({tag, ".su.busy"}, busy, 1);
        m_pready = 1'b0;
        tick();
        for (int k = 0; k <= waits; k++) begin
            chk({tag, ".ac.psel"}, m_psel, 1);
            chk({tag, ".ac.penable"}, m_penable, 1);
            chk({tag, ".ac.addr"}, m_paddr, a);
            chk({tag, ".ac.data"}, m_pwdata, d);
            chk({tag, ".ac.pwrite"}, m_pwrite, 1);
            chk({tag, ".ac.s_ready"}, s_ready, 0);
            if (k == waits) begin
                m_pready  = 1'b1;
                m_pslverr = slverr;
            end
            tick();
        end
        m_pslverr = 1'b0;
    endtask

    task automatic ack_msg(input logic [15:0] exp_sent);
        for (int k = 0; k < 2; k++) begin
            chk("wait.busy", busy, 1);
            chk("wait.psel", m_psel, 0);
            chk("wait.s_ready", s_ready, 0);
            tick();
        end
        msg_ack_irq = 1'b1;
        tick();
        msg_ack_irq = 1'b0;
        chk("ack.busy", busy, 0);
        chk("ack.s_ready", s_ready, 1);
        chk("ack.sent_count", sent_count, exp_sent);
    endtask

    // Depth-2 overlong sequence, per cycle after the second accept.
    logic        t2_psel  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic        t2_pen   [7] = '{0, 1, 0, 1, 0, 1, 0};
    logic [5:0]  t2_addr  [7] = '{6'h00, 6'h00, 6'h04, 6'h04, 6'h3C, 6'h3C, 6'h00};
    logic [31:0] t2_data  [7] = '{32'h50, 32'h50, 32'h51, 32'h51, 32'h1, 32'h1, 32'h0};

    initial begin
        preset = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        m_pready = 1'b1; m_pslverr = 1'b0; msg_ack_irq = 1'b0;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_ack = 1'b0;
        tick();
        tick();

        chk("rst.s_ready", s_ready, 1);
        chk("rst.psel", m_psel, 0);
        chk("rst.penable", m_penable, 0);
        chk("rst.paddr", m_paddr, 0);
        chk("rst.pwdata", m_pwdata, 0);
        chk("rst.pwrite", m_pwrite, 0);
        chk("rst.busy", busy, 0);
        chk("rst.err", err, 0);
        chk("rst.sent_count", sent_count, 0);
        preset = 1'b0;

        // Three-word message, zero wait states.
        push(32'hA0, 1'b0);
        push(32'hA1, 1'b0);
        push(32'hA2, 1'b1);
        xfer("m1.w0", 6'h00, 32'hA0, 0, 1'b0);
        xfer("m1.w1", 6'h04, 32'hA1, 0, 1'b0);
        xfer("m1.w2", 6'h08, 32'hA2, 0, 1'b0);
        xfer("m1.db", 6'h3C, 32'h1, 0, 1'b0);
        ack_msg(16'd1);
        chk("m1.err", err, 0);

        // Word 1 stalled three cycles by m_pready.
        push(32'hB0, 1'b0);
        push(32'hB1, 1'b0);
        push(32'hB2, 1'b1);
        xfer("m2.w0", 6'h00, 32'hB0, 0, 1'b0);
        xfer("m2.w1", 6'h04, 32'hB1, 3, 1'b0);
        xfer("m2.w2", 6'h08, 32'hB2, 0, 1'b0);
        xfer("m2.db", 6'h3C, 32'h1, 0, 1'b0);
        ack_msg(16'd2);

        // Slave error on the doorbell; ack already high when WAIT_ACK is entered.
        push(32'hC0, 1'b1);
        xfer("m3.w0", 6'h00, 32'hC0, 0, 1'b0);
        msg_ack_irq = 1'b1;
        xfer("m3.db", 6'h3C, 32'h1, 0, 1'b1);
        chk("m3.wait.busy", busy, 1);
        chk("m3.wait.psel", m_psel, 0);
        chk("m3.wait.err", err, 1);
        tick();
        msg_ack_irq = 1'b0;
        chk("m3.sent_count", sent_count, 3);
        chk("m3.busy", busy, 0);
        chk("m3.err_sticky", err, 1);
        tick();
        chk("m3.err_sticky2", err, 1);

        // Reset in the access phase of word 1.
        push(32'hD0, 1'b0);
        push(32'hD1, 1'b1);
        xfer("m4.w0", 6'h00, 32'hD0, 0, 1'b0);
        chk("m4.w1.su.addr", m_paddr, 6'h04);
        m_pready = 1'b0;
        tick();
        chk("m4.w1.ac.penable", m_penable, 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        m_pready = 1'b1;
        chk("m4.rst.psel", m_psel, 0);
        chk("m4.rst.penable", m_penable, 0);
        chk("m4.rst.s_ready", s_ready, 1);
        chk("m4.rst.sent_count", sent_count, 0);
        chk("m4.rst.err", err, 0);
        chk("m4.rst.busy", busy, 0);
        tick();
        chk("m4.idle.psel", m_psel, 0);
        push(32'hE0, 1'b1);
        xfer("m5.w0", 6'h00, 32'hE0, 0, 1'b0);
        xfer("m5.db", 6'h3C, 32'h1, 0, 1'b0);

`ifdef IPC_MSG_SENDER_TIMEOUT_EN
        for (int k = 0; k < 10; k++) begin
            chk("to.wait.busy", busy, 1);
            chk("to.wait.err", err, 0);
            tick();
        end
        chk("to.err", err, 1);
        chk("to.sent_count", sent_count, 0);
        chk("to.s_ready", s_ready, 1);
        chk("to.busy", busy, 0);
`else
        ack_msg(16'd1);
        chk("m5.err", err, 0);
`endif

        // Depth-2 sender fed five words with no end marker.
        b_valid = 1'b1;
        b_data  = 32'h50;
        chk("ovl.rdy0", b_ready, 1);
        tick();
        b_data = 32'h51;
        chk("ovl.rdy1", b_ready, 1);
        chk("ovl.err0", b_err, 0);
        tick();
        for (int c = 0; c < 7; c++) begin
            b_data  = 32'h52 + 32'(c);
            b_valid = c < 3;
            chk("ovl.s_ready", b_ready, 0);
            chk("ovl.err", b_err, 1);
            chk("ovl.busy", b_busy, 1);
            chk("ovl.psel", b_psel, t2_psel[c]);
            chk("ovl.penable", b_penable, t2_pen[c]);
            if (t2_psel[c]) begin
                chk("ovl.addr", b_paddr, t2_addr[c]);
                chk("ovl.data", b_pwdata, t2_data[c]);
            end
            tick();
        end
        b_valid = 1'b0;
        chk("ovl.still_wait", b_busy, 1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("ovl.sent", b_sent, 1);
        chk("ovl.ready_after", b_ready, 1);
        chk("ovl.err_after", b_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
